// File: rtl/ay_bus_ctrl_if.sv
// Host/bus signal bundle for ay_bus_ctrl: host request side, AY control lines and DA bus.
// master = host/bus model, slave = the sequencer.
interface ay_bus_ctrl_if #(
  parameter int NCHIP = 2
);
  logic             req;
  logic             we;
  logic [2:0]       sel;
  logic [3:0]       reg_a;
  logic [7:0]       wdata;
  logic             busy;
  logic             done;
  logic             err;
  logic [7:0]       rdata;
  logic [NCHIP-1:0] bdir;
  logic [NCHIP-1:0] bc1;
  logic             bc2;
  logic [7:0]       da_out;
  logic             da_oe;
  logic [7:0]       da_in;
  logic [2:0]       state;

  // Handshake: req is sampled on a rising edge only while busy=0 (or on the
  // edge where done rises); done is a one-clock pulse ending each transaction.
  modport master (
    output req, we, sel, reg_a, wdata, da_in,
    input  busy, done, err, rdata, bdir, bc1, bc2, da_out, da_oe, state
  );

  modport slave (
    input  req, we, sel, reg_a, wdata, da_in,
    output busy, done, err, rdata, bdir, bc1, bc2, da_out, da_oe, state
  );
endinterface

// File: rtl/ay_bus_ctrl.sv
// Synchronous BDIR/BC1/BC2 sequencer for one or more AY-3-8910/YM2149 chips on a shared DA bus.
// Each request runs ADDR -> GAP1 -> DATA -> GAP2 with programmable phase lengths; all outputs registered.
module ay_bus_ctrl #(
  parameter int          NCHIP  = 2,
  parameter int          T_ADDR = 2,
  parameter int          T_GAP  = 1,
  parameter int          T_WR   = 3,
  parameter int          T_RD   = 3,
  parameter logic [3:0]  A_HI   = 4'h0
) (
  input logic          clk,
  input logic          rst,
  ay_bus_ctrl_if.slave bus
);

  localparam int T_M1  = (T_ADDR > T_GAP) ? T_ADDR : T_GAP;
  localparam int T_M2  = (T_WR > T_RD) ? T_WR : T_RD;
  localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int CW    = $clog2(T_MAX) + 1;

  localparam logic [CW-1:0] L_ADDR = CW'(T_ADDR - 1);
  localparam logic [CW-1:0] L_GAP  = CW'(T_GAP - 1);
  localparam logic [CW-1:0] L_WR   = CW'(T_WR - 1);
  localparam logic [CW-1:0] L_RD   = CW'(T_RD - 1);
  localparam logic [3:0]    NCHIP_W = 4'(NCHIP);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_GAP1 = 3'd2,
    S_DATA = 3'd3,
    S_GAP2 = 3'd4
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_we;
  logic [2:0]       r_sel;
  logic [3:0]       r_reg_a;
  logic [7:0]       r_wdata;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [7:0]       r_rdata;
  logic [NCHIP-1:0] r_bdir;
  logic [NCHIP-1:0] r_bc1;
  logic             r_bc2;
  logic [7:0]       r_da_out;
  logic             r_da_oe;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_last;
  logic             w_accept;
  logic             w_capture;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic             w_we;
  logic [2:0]       w_sel;
  logic [3:0]       w_reg_a;
  logic [7:0]       w_wdata;
  logic             w_valid;
  logic [NCHIP-1:0] w_mask;
  logic [NCHIP-1:0] w_bdir_nxt;
  logic [NCHIP-1:0] w_bc1_nxt;
  logic [7:0]       w_da_out_nxt;
  logic             w_da_oe_nxt;

  // Next-state and phase counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_last      = (r_cnt == '0);
    case (r_state)
      S_IDLE: w_accept = bus.req;
      S_ADDR: begin
        if (w_last) begin
          w_state_nxt = S_GAP1;
          w_cnt_nxt   = L_GAP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_GAP1: begin
        if (w_last) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = r_we ? L_WR : L_RD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_state_nxt = S_GAP2;
          w_cnt_nxt   = L_GAP;
          w_capture   = !r_we;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_GAP2: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = !r_valid;
          w_accept    = bus.req;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_accept) begin
      w_state_nxt = S_ADDR;
      w_cnt_nxt   = L_ADDR;
    end
  end

  // Transaction fields as they will be after this edge (fresh on acceptance).
  always_comb begin
    w_we    = w_accept ? bus.we    : r_we;
    w_sel   = w_accept ? bus.sel   : r_sel;
    w_reg_a = w_accept ? bus.reg_a : r_reg_a;
    w_wdata = w_accept ? bus.wdata : r_wdata;
    w_valid = ({1'b0, w_sel} < NCHIP_W);
    w_mask  = '0;
    for (int i = 0; i < NCHIP; i++) begin
      w_mask[i] = w_valid && (w_sel == 3'(i));
    end
  end

  // Bus outputs are decoded from the next state so they register in step with it.
  always_comb begin
    w_bdir_nxt   = '0;
    w_bc1_nxt    = '0;
    w_da_out_nxt = 8'h00;
    w_da_oe_nxt  = 1'b0;
    case (w_state_nxt)
      S_ADDR: begin
        w_bdir_nxt   = w_mask;
        w_bc1_nxt    = w_mask;
        w_da_out_nxt = {A_HI, w_reg_a};
        w_da_oe_nxt  = 1'b1;
      end
      S_GAP1: begin
        w_da_oe_nxt  = w_we;
        w_da_out_nxt = w_we ? w_wdata : 8'h00;
      end
      S_DATA: begin
        if (w_we) begin
          w_bdir_nxt   = w_mask;
          w_da_out_nxt = w_wdata;
          w_da_oe_nxt  = 1'b1;
        end else begin
          w_bc1_nxt = w_mask;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_sel    <= 3'd0;
      r_reg_a  <= 4'd0;
      r_wdata  <= 8'h00;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 8'hFF;
      r_bdir   <= '0;
      r_bc1    <= '0;
      r_bc2    <= 1'b1;
      r_da_out <= 8'h00;
      r_da_oe  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_we     <= w_we;
      r_sel    <= w_sel;
      r_reg_a  <= w_reg_a;
      r_wdata  <= w_wdata;
      r_valid  <= w_valid;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_bdir   <= w_bdir_nxt;
      r_bc1    <= w_bc1_nxt;
      r_bc2    <= 1'b1;
      r_da_out <= w_da_out_nxt;
      r_da_oe  <= w_da_oe_nxt;
      if (w_capture) begin
        r_rdata <= r_valid ? bus.da_in : 8'hFF;
      end
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.err    = r_err;
  assign bus.rdata  = r_rdata;
  assign bus.bdir   = r_bdir;
  assign bus.bc1    = r_bc1;
  assign bus.bc2    = r_bc2;
  assign bus.da_out = r_da_out;
  assign bus.da_oe  = r_da_oe;
  assign bus.state  = r_state;

endmodule

// File: tb/tb_ay_bus_ctrl.sv
// Self-checking bench for ay_bus_ctrl: directed transactions, expected bus codes and done
// results queued by the driver and checked by independent negedge monitors.
module tb_ay_bus_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ay_bus_ctrl_if #(.NCHIP(2)) bus ();
  ay_bus_ctrl_if #(.NCHIP(2)) bus2 ();

  ay_bus_ctrl #(.NCHIP(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ay_bus_ctrl #(.NCHIP(2), .T_ADDR(1), .T_GAP(2), .T_WR(4)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit bus_chk_en = 1'b1;

  // bus entry: {bdir[1:0], bc1[1:0], da_oe, da_out[7:0]}
  logic [12:0] exp_bus_q[$];
  // done entry: {cycle[31:0], err, rdata[7:0]}
  logic [40:0] exp_done_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus monitor: every busy cycle must match the next queued bus code.
  always @(negedge clk) begin
    if (!rst && bus_chk_en && bus.busy === 1'b1) begin
      chk("bc2_high", 32'(bus.bc2), 32'd1);
      if (exp_bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_unexpected actual=busy required=idle (t=%0t)", $time);
      end else begin
        logic [12:0] e;
        e = exp_bus_q.pop_front();
        chk("bus_code", 32'({bus.bdir, bus.bc1, bus.da_oe, bus.da_out}), 32'(e));
      end
    end
  end

  // Done monitor: each done pulse pops one expected result.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (exp_done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected actual=1 required=0 (t=%0t)", $time);
      end else begin
        logic [40:0] e;
        e = exp_done_q.pop_front();
        chk("done_cycle", cyc, e[40:9]);
        chk("done_err", 32'(bus.err), 32'(e[8]));
        chk("done_rdata", 32'(bus.rdata), 32'(e[7:0]));
        chk("done_busy", 32'(bus.busy), 32'(bus.state != 3'd0));
      end
    end else if (!rst && bus.err === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL err_without_done actual=1 required=0 (t=%0t)", $time);
    end
  end

  task automatic push_exp(input int e0, input logic we, input logic [2:0] sel,
                          input logic [3:0] reg_a, input logic [7:0] wdata,
                          input logic [7:0] rd_exp);
    logic [1:0] m;
    logic       err;
    m   = (sel < 3'd2) ? (2'b01 << sel) : 2'b00;
    err = (sel >= 3'd2);
    repeat (2) exp_bus_q.push_back({m, m, 1'b1, 4'h0, reg_a});
    if (we) begin
      exp_bus_q.push_back({2'b00, 2'b00, 1'b1, wdata});
      repeat (3) exp_bus_q.push_back({m, 2'b00, 1'b1, wdata});
    end else begin
      exp_bus_q.push_back({2'b00, 2'b00, 1'b0, 8'h00});
      repeat (3) exp_bus_q.push_back({2'b00, m, 1'b0, 8'h00});
    end
    exp_bus_q.push_back({2'b00, 2'b00, 1'b0, 8'h00});
    exp_done_q.push_back({32'(e0 + 7), err, rd_exp});
  endtask

  task automatic drive(input logic we, input logic [2:0] sel, input logic [3:0] reg_a,
                       input logic [7:0] wdata);
    bus.we    = we;
    bus.sel   = sel;
    bus.reg_a = reg_a;
    bus.wdata = wdata;
  endtask

  task automatic issue(input logic we, input logic [2:0] sel, input logic [3:0] reg_a,
                       input logic [7:0] wdata, input logic [7:0] rd_exp, output int e0);
    @(negedge clk);
    drive(we, sel, reg_a, wdata);
    bus.req = 1'b1;
    e0 = cyc + 1;
    push_exp(e0, we, sel, reg_a, wdata, rd_exp);
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && (exp_done_q.size() != 0 || exp_bus_q.size() != 0); i++)
      @(negedge clk);
    chk("drain_done_q", exp_done_q.size(), 0);
    chk("drain_bus_q", exp_bus_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
    chk({tag, "_rdata"}, 32'(bus.rdata), 32'hFF);
    chk({tag, "_bdir"}, 32'(bus.bdir), 32'd0);
    chk({tag, "_bc1"}, 32'(bus.bc1), 32'd0);
    chk({tag, "_bc2"}, 32'(bus.bc2), 32'd1);
    chk({tag, "_da_out"}, 32'(bus.da_out), 32'd0);
    chk({tag, "_da_oe"}, 32'(bus.da_oe), 32'd0);
  endtask

  initial begin
    int e0;
    int lat;
    bit seen;
    bus.req  = 1'b0;
    drive(1'b0, 3'd0, 4'd0, 8'h00);
    bus.da_in  = 8'h00;
    bus2.req   = 1'b0;
    bus2.we    = 1'b0;
    bus2.sel   = 3'd0;
    bus2.reg_a = 4'd0;
    bus2.wdata = 8'h00;
    bus2.da_in = 8'h00;

    // Reset asserted mid-clock: outputs must take reset values immediately.
    #2 rst = 1'b1;
    #1 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Write to chip 0, reg 7, data 3E.
    issue(1'b1, 3'd0, 4'd7, 8'h3E, 8'hFF, e0);
    wait_drain();

    // Read from chip 1, reg 14, bus returns A5.
    bus.da_in = 8'hA5;
    issue(1'b0, 3'd1, 4'd14, 8'h00, 8'hA5, e0);
    wait_drain();

    // Invalid chip read: no control activity, err with done, rdata FF.
    issue(1'b0, 3'd3, 4'd2, 8'h00, 8'hFF, e0);
    wait_drain();

    // Valid read from chip 0 returning 5A.
    bus.da_in = 8'h5A;
    issue(1'b0, 3'd0, 4'd5, 8'h00, 8'h5A, e0);
    wait_drain();

    // Back-to-back writes with req held high; second accepted on the done edge.
    @(negedge clk);
    drive(1'b1, 3'd1, 4'd3, 8'h11);
    bus.req = 1'b1;
    e0 = cyc + 1;
    push_exp(e0, 1'b1, 3'd1, 4'd3, 8'h11, 8'h5A);
    @(negedge clk);
    drive(1'b1, 3'd0, 4'hC, 8'hC3);
    push_exp(e0 + 7, 1'b1, 3'd0, 4'hC, 8'hC3, 8'h5A);
    repeat (7) @(negedge clk);
    bus.req = 1'b0;
    wait_drain();

    // Request pulse during busy must be ignored.
    issue(1'b1, 3'd0, 4'd1, 8'h77, 8'h5A, e0);
    @(negedge clk);
    drive(1'b0, 3'd1, 4'd9, 8'h00);
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);

    // Abort a read in its DATA phase with a mid-clock reset.
    bus_chk_en = 1'b0;
    bus.da_in = 8'h99;
    @(negedge clk);
    drive(1'b0, 3'd1, 4'd2, 8'h00);
    bus.req = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    bus.req = 1'b0;
    while (cyc < e0 + 4) @(negedge clk);
    chk("abort_in_data", 32'(bus.bc1), 32'b10);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_rdata_after", 32'(bus.rdata), 32'hFF);
    bus_chk_en = 1'b1;

    // Alternate timing instance: T_ADDR=1, T_GAP=2, T_WR=4 -> done at E0+9.
    @(negedge clk);
    bus2.we    = 1'b1;
    bus2.sel   = 3'd0;
    bus2.reg_a = 4'd1;
    bus2.wdata = 8'h42;
    bus2.req   = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    bus2.req = 1'b0;
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (bus2.done === 1'b1) begin
        seen = 1'b1;
        lat  = cyc - e0;
      end else begin
        @(negedge clk);
      end
    end
    chk("param_done_seen", 32'(seen), 32'd1);
    chk("param_latency", lat, 9);
    chk("param_rdata", 32'(bus2.rdata), 32'hFF);

    wait_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ay_bus_ctrl.md
Name: ay_bus_ctrl

Overview:
- Clocked, parametrised bus sequencer for one or more AY-3-8910/YM2149 sound chips on a shared DA[7:0] bus.
- Replaces the asynchronous strobe/iwrbt gate-and-diode decode with a synchronous FSM on the system clock.
- Each host transaction produces a full address-latch, gap, data-write or data-read, gap sequence on BDIR/BC1/BC2, with programmable phase lengths.
- Supports up to NCHIP chips (TurboSound-style) with per-chip BDIR/BC1.

Parameters:
- NCHIP, 2, number of AY chips driven; range 1..8.
- T_ADDR, 2, clocks the address-latch phase is held; >=1.
- T_GAP, 1, clocks of inactive bus between phases and after data; >=1.
- T_WR, 3, clocks the write-data phase is held; >=1.
- T_RD, 3, clocks the read phase is held; >=1.
- A_HI, 4'h0, upper nibble placed on DA during the address latch (chip mask address).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  transaction request, sampled only when busy=0.
- we  in  1  1 = register write, 0 = register read.
- sel  in  3  target chip index.
- reg_a  in  4  AY register number.
- wdata  in  8  write data.
- busy  out  1  transaction in progress.
- done  out  1  one-clock pulse at transaction end.
- err  out  1  one-clock pulse with done when sel >= NCHIP.
- rdata  out  8  read result, held until the next read completes.
- bdir  out  NCHIP  per-chip BDIR.
- bc1  out  NCHIP  per-chip BC1.
- bc2  out  1  common BC2.
- da_out  out  8  DA bus drive value.
- da_oe  out  1  DA output enable.
- da_in  in  8  DA bus input.

Behaviour:
- Reset (async, immediate), all outputs: busy=0, done=0, err=0, rdata=8'hFF, bdir=0, bc1=0, bc2=1, da_out=0, da_oe=0, FSM=IDLE.
- All outputs are registered.
- Bus codes with bc2=1 constant:
  - INACTIVE: bdir=0, bc1=0.
  - LATCH: bdir=1, bc1=1.
  - WRITE: bdir=1, bc1=0.
  - READ: bdir=0, bc1=1.
- Only bit sel of bdir/bc1 carries a non-INACTIVE code. All other bits stay 0.
- If sel >= NCHIP, all bits stay 0 for the whole transaction, but the timing is unchanged.
- FSM states: IDLE, ADDR, GAP1, DATA, GAP2.
- Acceptance at edge E0, when req=1 and busy=0 are sampled:
  - we, sel, reg_a and wdata are captured.
  - busy=1, state=ADDR.
- ADDR, T_ADDR clocks: LATCH code, da_out={A_HI,reg_a}, da_oe=1.
- GAP1, T_GAP clocks: INACTIVE code.
  - Write: da_oe=1, da_out=wdata.
  - Read: da_oe=0.
- DATA, write, T_WR clocks: WRITE code, da_oe=1, da_out=wdata.
- DATA, read, T_RD clocks: READ code, da_oe=0.
  - da_in is captured into rdata on the last DATA clock.
  - If sel is invalid, rdata=8'hFF instead.
- GAP2, T_GAP clocks: INACTIVE code, da_oe=0.
- At edge E0+T_ADDR+T_DATA+2*T_GAP: busy=0, done=1 for one clock, err=1 in that same clock if sel was invalid, state=IDLE.
- req while busy=1 is ignored, not queued.
- A new req may be accepted on the same edge where done rises. The next transaction's ADDR phase is then contiguous with done.
- Write transactions do not modify rdata.
- Phase counter width is clog2(max(T_ADDR,T_GAP,T_WR,T_RD))+1. It reloads on every state change, with no wrap-around within a phase.
- rst mid-transaction aborts it. No done pulse is produced and rdata keeps its reset value 8'hFF.
- bc2 is never deasserted in operation. bdir=1 and bc1=1 are never driven on the same chip while da_oe=0.

Test Plan:
- Reset: assert rst mid-clock -> outputs immediately at reset values, bc2=1, rdata=8'hFF.
- Write, defaults, sel=0, reg_a=7, wdata=8'h3E, req at E0:
  - bdir[0]/bc1[0] = 11 for 2 clocks with da_out=8'h07.
  - 00 for 1 clock.
  - 10 for 3 clocks with da_out=8'h3E.
  - 00 for 1 clock.
  - done pulses at E0+7, bdir[1]=bc1[1]=0 throughout.
- Read, sel=1, reg_a=14, da_in=8'hA5 during DATA:
  - bdir[1]/bc1[1]=01 for 3 clocks, da_oe=0.
  - rdata=8'hA5 at done (E0+7).
- Invalid chip, sel=3 read:
  - no bdir/bc1 activity on any chip.
  - done and err together at E0+7, rdata=8'hFF.
- Back-to-back: req held high for two writes -> second ADDR starts on the done edge; req pulses during busy are ignored (exactly 2 done pulses).
- Abort and parameters:
  - rst during DATA of a read -> no done, rdata=8'hFF.
  - With T_ADDR=1, T_GAP=2, T_WR=4, a write's done lands at E0+9.
